// File: rtl/fp_reduce_scheduler_pkg.sv
// Shared constants and state encoding for the FP reduction scheduler.
package fp_reduce_scheduler_pkg;

  localparam int unsigned FpWidth   = 32;
  localparam int unsigned DefAddLat = 3;
  localparam int unsigned DefMaxCh  = 128;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccum  = 2'd1,
    StOutput = 2'd2
  } state_e;

endpackage

// File: rtl/fp_reduce_scheduler_fp_adder.sv
// Fixed-latency single-precision adder: combinational add/round, then a Lat-deep pipe.
module fp_reduce_scheduler_fp_adder
  import fp_reduce_scheduler_pkg::*;
#(
  parameter int unsigned Lat = DefAddLat
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FpWidth-1:0] a_i,
  input  logic [FpWidth-1:0] b_i,
  input  logic               mode_i,   // 0 add, 1 subtract
  input  logic               rmode_i,  // 0 nearest-even, 1 toward zero
  input  logic               valid_i,
  output logic [FpWidth-1:0] result_o,
  output logic               valid_o
);

  logic [31:0] b_eff, big, sml, sum_res;
  logic [7:0]  e_big, e_sml, d;
  logic [23:0] m_big, m_sml;
  logic [26:0] sml_ext, sml_sh, norm;
  logic [27:0] sum;
  logic [9:0]  exp_w;
  logic [4:0]  lz, sh;
  logic [24:0] mant;
  logic        rnd, sticky;

  logic [31:0]    res_q [Lat];
  logic [Lat-1:0] vld_q;

  // Align, add, normalise and round; big always holds the larger magnitude
  always_comb begin
    b_eff = {b_i[31] ^ mode_i, b_i[30:0]};
    if (a_i[30:0] >= b_eff[30:0]) begin
      big = a_i;
      sml = b_eff;
    end else begin
      big = b_eff;
      sml = a_i;
    end
    // Subnormals use exponent 1 with no hidden bit
    e_big   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    e_sml   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    m_big   = {big[30:23] != 8'd0, big[22:0]};
    m_sml   = {sml[30:23] != 8'd0, sml[22:0]};
    d       = e_big - e_sml;
    sml_ext = {m_sml, 3'b000};
    sticky  = 1'b0;
    if (d > 8'd26) begin
      sml_sh = {26'd0, |m_sml};
    end else begin
      sticky = |(sml_ext & ((27'd1 << d) - 27'd1));
      sml_sh = (sml_ext >> d) | {26'd0, sticky};
    end
    if (big[31] ^ sml[31]) sum = {1'b0, m_big, 3'b000} - {1'b0, sml_sh};
    else                   sum = {1'b0, m_big, 3'b000} + {1'b0, sml_sh};

    exp_w = {2'b00, e_big};
    lz    = 5'd0;
    sh    = 5'd0;
    norm  = sum[26:0];
    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      exp_w = exp_w + 10'd1;
    end else begin
      for (int k = 0; k <= 26; k++) begin
        if (sum[k]) lz = 5'(26 - k);
      end
      // Never shift below the minimum exponent; the rest becomes subnormal
      sh    = (10'(lz) < exp_w) ? lz : 5'(exp_w - 10'd1);
      norm  = sum[26:0] << sh;
      exp_w = exp_w - 10'(sh);
      if (!norm[26]) exp_w = 10'd0;
    end

    rnd  = !rmode_i && norm[2] && (norm[1] || norm[0] || norm[3]);
    mant = {1'b0, norm[26:3]} + 25'(rnd);
    if (mant[24]) begin
      exp_w = exp_w + 10'd1;
      mant  = mant >> 1;
    end else if (exp_w == 10'd0 && mant[23]) begin
      exp_w = 10'd1;
    end

    if (big[30:23] == 8'hFF)    sum_res = big;
    else if (sum == 28'd0)      sum_res = 32'd0;
    else if (exp_w >= 10'd255)  sum_res = {big[31], 8'hFF, 23'd0};
    else                        sum_res = {big[31], exp_w[7:0], mant[22:0]};
  end

  // Latency pipe for result and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < Lat; k++) res_q[k] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      res_q[0] <= sum_res;
      for (int k = 1; k < Lat; k++) begin
        vld_q[k] <= vld_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end

  assign result_o = res_q[Lat-1];
  assign valid_o  = vld_q[Lat-1];

endmodule

// File: rtl/fp_reduce_scheduler.sv
// Streams Num_Ch operands into a shared pipelined adder, pairing inputs, results and
// one holding register until a single sum remains.
module fp_reduce_scheduler
  import fp_reduce_scheduler_pkg::*;
#(
  parameter int unsigned ADD_LAT = DefAddLat,
  parameter int unsigned MAX_CH  = DefMaxCh
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [7:0]         Num_Ch,
  input  logic [FpWidth-1:0] Data_In,
  input  logic               Valid_In,
  output logic               In_Ready,
  output logic [FpWidth-1:0] Data_Out,
  output logic               Valid_Out,
  input  logic               Out_Ready,
  output logic               Busy
);

  localparam logic [7:0] MaxCh = 8'(MAX_CH);

  state_e             state_q;
  logic [7:0]         num_q, rx_cnt_q, add_cnt_q, inflight_q, rx_cnt_d;
  logic [FpWidth-1:0] h_q, h_d, data_out_q, op_a, op_b, add_res;
  logic               h_vld_q, h_vld_d, in_ready_q, valid_out_q, busy_q;
  logic               in_fire, res_fire, issue, add_vld, done;

  assign in_fire  = Valid_In && in_ready_q;
  // Results only count while a reduction owns them
  assign res_fire = add_vld && (state_q == StAccum) && (inflight_q != 8'd0);
  assign rx_cnt_d = rx_cnt_q + 8'(in_fire);
  assign done     = (state_q == StAccum) && (rx_cnt_q == num_q) &&
                    (add_cnt_q == num_q - 8'd1) && (inflight_q == 8'd0) && h_vld_q;

  // Pair this cycle's input, adder result and holding register
  always_comb begin
    issue   = 1'b0;
    op_a    = Data_In;
    op_b    = add_res;
    h_d     = h_q;
    h_vld_d = h_vld_q;
    if (in_fire && res_fire) begin
      issue = 1'b1;
    end else if (in_fire || res_fire) begin
      if (h_vld_q) begin
        issue   = 1'b1;
        op_a    = h_q;
        op_b    = in_fire ? Data_In : add_res;
        h_vld_d = 1'b0;
      end else begin
        h_d     = in_fire ? Data_In : add_res;
        h_vld_d = 1'b1;
      end
    end
  end

  // Control FSM, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_q       <= 8'd0;
      rx_cnt_q    <= 8'd0;
      add_cnt_q   <= 8'd0;
      inflight_q  <= 8'd0;
      h_q         <= '0;
      h_vld_q     <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start && (Num_Ch != 8'd0) && (Num_Ch <= MaxCh)) begin
            state_q    <= StAccum;
            num_q      <= Num_Ch;
            rx_cnt_q   <= 8'd0;
            add_cnt_q  <= 8'd0;
            inflight_q <= 8'd0;
            h_vld_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StAccum: begin
          rx_cnt_q   <= rx_cnt_d;
          add_cnt_q  <= add_cnt_q + 8'(issue);
          inflight_q <= inflight_q + 8'(issue) - 8'(res_fire);
          h_q        <= h_d;
          h_vld_q    <= h_vld_d;
          in_ready_q <= (rx_cnt_d < num_q);
          if (done) begin
            state_q     <= StOutput;
            data_out_q  <= h_q;
            valid_out_q <= 1'b1;
            h_vld_q     <= 1'b0;
            in_ready_q  <= 1'b0;
          end
        end
        StOutput: begin
          if (Out_Ready) begin
            state_q     <= StIdle;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fp_reduce_scheduler_fp_adder #(
    .Lat (ADD_LAT)
  ) u_adder (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_i      (op_a),
    .b_i      (op_b),
    .mode_i   (1'b0),
    .rmode_i  (1'b0),
    .valid_i  (issue),
    .result_o (add_res),
    .valid_o  (add_vld)
  );

  assign In_Ready  = in_ready_q;
  assign Data_Out  = data_out_q;
  assign Valid_Out = valid_out_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_fp_reduce_scheduler.sv
// Bench for fp_reduce_scheduler: directed cases with literal sums plus random integer
// reductions checked against a sum-and-convert reference model.
module tb_fp_reduce_scheduler;

  localparam int AddLat = 3;
  localparam int MaxCh  = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Num_Ch = 8'd0;
  logic [31:0] Data_In = 32'd0;
  logic        Valid_In = 1'b0;
  logic        Out_Ready = 1'b1;
  logic        In_Ready, Valid_Out, Busy;
  logic [31:0] Data_Out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fp_reduce_scheduler #(
    .ADD_LAT (AddLat),
    .MAX_CH  (MaxCh)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Num_Ch    (Num_Ch),
    .Data_In   (Data_In),
    .Valid_In  (Valid_In),
    .In_Ready  (In_Ready),
    .Data_Out  (Data_Out),
    .Valid_Out (Valid_Out),
    .Out_Ready (Out_Ready),
    .Busy      (Busy)
  );

  typedef enum {PIdle, PAccum, POut} phase_t;
  phase_t      phase = PIdle;
  int          m_n, m_rx, m_lat, m_adds, m_ir, m_pulses;
  logic [31:0] m_exp;
  logic [31:0] ops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Exact integer to single-precision conversion, |v| < 2^24
  function automatic logic [31:0] itof(input int v);
    int unsigned m;
    int          p;
    logic        s;
    if (v == 0) return 32'd0;
    s = (v < 0);
    m = s ? int'(-v) : v;
    p = 0;
    for (int k = 0; k < 32; k++) if (m[k]) p = k;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  function automatic int lat_bound(input int n);
    int c = 0;
    while ((1 << c) < n) c++;
    return (c + 1) * (AddLat + 1) + 2;
  endfunction

  // Reference model and per-cycle comparison
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(In_Ready), 32'd0);
      chk("rst_valid_out", 32'(Valid_Out), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_data_out", Data_Out, 32'd0);
      phase = PIdle;
    end else begin
      chk("busy", 32'(Busy), 32'(phase != PIdle));
      chk("in_ready", 32'(In_Ready), 32'(phase == PAccum && m_rx < m_n));
      if (phase == PIdle) begin
        chk("valid_idle", 32'(Valid_Out), 32'd0);
        if (Start && Num_Ch >= 1 && Num_Ch <= MaxCh) begin
          phase  = PAccum;
          m_n    = int'(Num_Ch);
          m_rx   = 0;
          m_lat  = 0;
          m_adds = 0;
          m_ir   = 0;
        end
      end else if (phase == PAccum) begin
        if (dut.u_adder.valid_i) m_adds++;
        if (Valid_In && In_Ready && dut.u_adder.valid_o) m_ir++;
        if (Valid_Out) begin
          if (m_rx != m_n) fail("early_valid");
          chk("latency_ok", 32'(m_lat + 1 <= lat_bound(m_n)), 32'd1);
          chk("add_cnt", 32'(m_adds), 32'(m_n - 1));
          phase = POut;
        end else if (m_rx == m_n) begin
          m_lat++;
        end
        if (Valid_In && In_Ready) m_rx++;
      end
      if (phase == POut) begin
        chk("valid_out", 32'(Valid_Out), 32'd1);
        chk("data_out", Data_Out, m_exp);
        if (Out_Ready) begin
          m_pulses++;
          phase = PIdle;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int n);
    Num_Ch = 8'(n);
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
  endtask

  task automatic feed(input int count, input int gap_pct);
    int   i = 0;
    int   budget = 0;
    logic fire;
    while (i < count && budget < 5000) begin
      Valid_In = (32'($urandom_range(99)) >= 32'(gap_pct));
      Data_In  = ops[i];
      @(negedge clk);
      fire = Valid_In && In_Ready;
      tick();
      if (fire) i++;
      budget++;
    end
    Valid_In = 1'b0;
    if (i < count) fail("feed_timeout");
  endtask

  task automatic drain(input int hold, input bit poke);
    int seen = 0;
    int budget = 0;
    Out_Ready = (hold == 0);
    while (phase != PIdle && budget < 2000) begin
      @(negedge clk);
      if (Valid_Out) seen++;
      tick();
      budget++;
      Out_Ready = (seen >= hold);
      Start     = poke && (seen == 2);
      Num_Ch    = 8'd3;
    end
    Start     = 1'b0;
    Out_Ready = 1'b1;
    if (phase != PIdle) begin
      fail("drain_timeout");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
  endtask

  task automatic reduce(input int n, input int gap, input int hold, input bit poke,
                        input logic [31:0] exp);
    m_exp    = exp;
    m_pulses = 0;
    start(n);
    feed(n, gap);
    drain(hold, poke);
    chk("one_pulse", 32'(m_pulses), 32'd1);
    tick();
  endtask

  initial begin
    int n, gap, hold, sum, v;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Four ones back to back
    ops = {};
    repeat (4) ops.push_back(32'h3F800000);
    reduce(4, 0, 0, 1'b0, 32'h40800000);

    // Single operand passes through untouched
    ops = {};
    ops.push_back(32'h40490FDB);
    reduce(1, 0, 0, 1'b0, 32'h40490FDB);

    // 1..8 back to back forces input/result coincidence
    ops = {};
    ops.push_back(32'h3F800000); ops.push_back(32'h40000000);
    ops.push_back(32'h40400000); ops.push_back(32'h40800000);
    ops.push_back(32'h40A00000); ops.push_back(32'h40C00000);
    ops.push_back(32'h40E00000); ops.push_back(32'h41000000);
    reduce(8, 0, 0, 1'b0, 32'h42100000);
    chk("ir_issued", 32'(m_ir > 0), 32'd1);

    // Maximum channel count with random input gaps
    ops = {};
    repeat (128) ops.push_back(32'h3F800000);
    reduce(128, 40, 0, 1'b0, 32'h43000000);

    // Output held for five cycles, Start poked during the hold
    ops = {};
    repeat (3) ops.push_back(32'h40000000);
    reduce(3, 0, 5, 1'b1, 32'h40C00000);

    // Illegal channel counts are ignored
    start(0);
    repeat (3) tick();
    start(200);
    repeat (3) tick();

    // Reset in the middle of a 16-operand reduction
    ops = {};
    repeat (16) ops.push_back(32'h3F800000);
    m_exp = 32'd0;
    start(16);
    feed(6, 0);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (AddLat + 2) tick();
    ops = {};
    ops.push_back(32'h40000000);
    ops.push_back(32'h40000000);
    reduce(2, 0, 0, 1'b0, 32'h40800000);

    // Random signed-integer reductions
    for (int r = 0; r < 20; r++) begin
      n    = int'($urandom_range(1, MaxCh));
      gap  = int'($urandom_range(0, 60));
      hold = int'($urandom_range(0, 3));
      ops  = {};
      sum  = 0;
      for (int k = 0; k < n; k++) begin
        v   = int'($urandom_range(0, 2000)) - 1000;
        sum += v;
        ops.push_back(itof(v));
      end
      reduce(n, gap, hold, 1'b0, itof(sum));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fp_reduce_scheduler.md
FP_REDUCE_SCHEDULER -- requirements
Module: fp_reduce_scheduler

Interface
REQ-001 Parameter ADD_LAT, default 3, fixed cycle latency from FP_Adder Valid_In to Valid_Out.
REQ-002 Parameter MAX_CH, default 128, largest channel count per reduction.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Start  input  1  one-cycle pulse launching a reduction; honoured only in IDLE.
REQ-006 Num_Ch  input  8  operands to sum (1..MAX_CH); sampled with Start.
REQ-007 Data_In  input  32  IEEE-754 single operand.
REQ-008 Valid_In  input  1  Data_In valid; transfer when Valid_In && In_Ready.
REQ-009 In_Ready  output  1  scheduler accepts an operand this cycle.
REQ-010 Data_Out  output  32  final sum.
REQ-011 Valid_Out  output  1  Data_Out valid; held until Out_Ready.
REQ-012 Out_Ready  input  1  consumer accepts Data_Out.
REQ-013 Busy  output  1  high in any state other than IDLE.

Function
REQ-014 States IDLE, ACCUM, OUTPUT; IDLE->ACCUM on Start with 1<=Num_Ch<=MAX_CH; ACCUM->OUTPUT on completion (REQ-021); OUTPUT->IDLE on Valid_Out && Out_Ready.
REQ-015 Start with Num_Ch==0 or Num_Ch>MAX_CH, or Start outside IDLE, is ignored; no state change.
REQ-016 In_Ready is 1 in ACCUM while rx_cnt < Num_Ch, else 0; rx_cnt counts accepted operands.
REQ-017 One shared FP_Adder, Mode=0, RMode=0; at most one issue per cycle; never stalled.
REQ-018 One holding register H with valid flag; operand sources per cycle: accepted input (I), adder result (R), H.
REQ-019 Pairing rules per cycle: I and R both present -> issue I+R, H unchanged; exactly one of I/R present and H valid -> issue H+that, H cleared; exactly one present and H empty -> load H; none -> no action.
REQ-020 Counters: add_cnt increments per issue; inflight +1 on issue, -1 on adder Valid_Out, unchanged when both.
REQ-021 Completion: rx_cnt==Num_Ch, add_cnt==Num_Ch-1, inflight==0, H valid; next cycle Data_Out=H, Valid_Out=1.
REQ-022 Num_Ch==1: single operand loads H, no adds, OUTPUT entered the cycle after acceptance.
REQ-023 Data_Out, Valid_Out stable while Valid_Out && !Out_Ready.
REQ-024 Latency from last operand accepted to Valid_Out bounded by (ceil(log2 Num_Ch)+1)*(ADD_LAT+1)+2 cycles.
REQ-025 Summation order is data-arrival dependent; bit-exactness guaranteed only for exactly representable partial sums.
REQ-026 Counters 8 bits; MAX_CH<=255 required; no wrap possible within legal Num_Ch.

Reset
REQ-027 rst_n low: state IDLE; In_Ready, Valid_Out, Busy 0; Data_Out 0; H valid 0; rx_cnt, add_cnt, inflight 0.
REQ-028 Reset mid-reduction abandons operation; adder results arriving after release are discarded (inflight 0 in IDLE ignores Valid_Out).

Structure
REQ-029 Shared package holds state encoding (2-bit IDLE/ACCUM/OUTPUT), FP width 32, default ADD_LAT and MAX_CH.
REQ-030 Exactly one sub-module: FP_Adder instance; all scheduling logic in fp_reduce_scheduler.

Verification
REQ-031 Num_Ch=4, inputs 0x3F800000 x4 back-to-back, Out_Ready=1 -> Data_Out=0x40800000 (4.0), one Valid_Out pulse, Busy drops next cycle.
REQ-032 Num_Ch=128, 128 x 0x3F800000 with random Valid_In gaps -> Data_Out=0x43000000 (128.0), add_cnt=127.
REQ-033 Num_Ch=1, input 0x40490FDB -> Data_Out=0x40490FDB unchanged, no adder issue.
REQ-034 Num_Ch=8, inputs 1.0..8.0 timed so input and adder result coincide -> I+R issued, Data_Out=0x42100000 (36.0).
REQ-035 Out_Ready=0 for 5 cycles after Valid_Out -> Data_Out held; Start during hold ignored; Num_Ch=0 Start in IDLE ignored.
REQ-036 rst_n low mid-ACCUM of Num_Ch=16 -> all outputs 0 next edge; fresh Num_Ch=2 {2.0,2.0} -> 0x40800000.
